// File: rtl/vga_fill_avalon_if.sv
// rtl/vga_fill_avalon_if.sv - Avalon-MM register bus bundle for the VGA fill block
interface vga_fill_avalon_if;
   logic [3:0]  address;
   logic        read;
   logic [31:0] readdata;
   logic        write;
   logic [31:0] writedata;
   logic        waitrequest;

   modport slave (
      input  address, read, write, writedata,
      output readdata, waitrequest
   );

   modport master (
      output address, read, write, writedata,
      input  readdata, waitrequest
   );
endinterface

// File: rtl/vga_fill_avalon.sv
// rtl/vga_fill_avalon.sv - Avalon-MM pixel queue plus clipped rectangle-fill engine
module vga_fill_avalon #(
   parameter int H_RES      = 160,
   parameter int V_RES      = 120,
   parameter int XW         = 8,
   parameter int YW         = 7,
   parameter int CW         = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   vga_fill_avalon_if.slave  bus,
   output logic [XW-1:0]     pix_x,
   output logic [YW-1:0]     pix_y,
   output logic [CW-1:0]     pix_colour,
   output logic              pix_plot,
   output logic              busy
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int PXW = ((XW > 8) ? XW : 8) + 1;
   localparam int PYW = ((YW > 8) ? YW : 8) + 1;
   localparam int EW  = XW + YW + CW;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FILL} state_t;

   state_t          r_state, w_state_nxt;

   logic [EW-1:0]   r_fifo [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [AW:0]     r_count, w_count_nxt;

   logic [XW-1:0]   r_x0;
   logic [YW-1:0]   r_y0;
   logic [7:0]      r_w, r_h;
   logic [XW-1:0]   r_fx0;
   logic [YW-1:0]   r_fy0;
   logic [7:0]      r_fw, r_fh, r_cx, r_cy;
   logic [CW-1:0]   r_fcol;

   logic [XW-1:0]   r_pix_x;
   logic [YW-1:0]   r_pix_y;
   logic [CW-1:0]   r_pix_colour;
   logic            r_pix_plot;
   logic            r_busy;

   logic [XW-1:0]   w_x;
   logic [YW-1:0]   w_y;
   logic [CW-1:0]   w_c;
   logic            w_inb, w_empty, w_full;
   logic            w_plot_wr, w_fill_wr, w_wait, w_accept;
   logic            w_push, w_pop, w_fill_go;
   logic            w_last_x, w_last_y;
   logic [PXW-1:0]  w_px;
   logic [PYW-1:0]  w_py;
   logic            w_pinb;
   logic [31:0]     w_status;
   logic            w_unused;

   assign w_x = bus.writedata[16 +: XW];
   assign w_y = bus.writedata[24 +: YW];
   assign w_c = bus.writedata[0 +: CW];
   assign w_inb = ({1'b0, w_x} < (XW+1)'(H_RES)) && ({1'b0, w_y} < (YW+1)'(V_RES));

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));

   // Out-of-bounds plots are dropped, so they never wait on a full queue.
   assign w_plot_wr = bus.write && (bus.address == 4'd0);
   assign w_fill_wr = bus.write && (bus.address == 4'd3);
   assign w_wait    = (w_plot_wr && w_inb && w_full) || (w_fill_wr && (r_state != S_IDLE));
   assign w_accept  = bus.write && !w_wait;
   assign w_push    = w_accept && (bus.address == 4'd0) && w_inb;
   assign w_fill_go = w_accept && (bus.address == 4'd3);
   assign w_pop     = (r_state != S_FILL) && !w_empty;

   assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

   assign w_last_x = (r_cx == r_fw - 8'd1);
   assign w_last_y = (r_cy == r_fh - 8'd1);
   assign w_px     = PXW'(r_fx0) + PXW'(r_cx);
   assign w_py     = PYW'(r_fy0) + PYW'(r_cy);
   assign w_pinb   = (w_px < PXW'(H_RES)) && (w_py < PYW'(V_RES));

   assign w_status = {24'd0, 4'(r_count), 1'b0, w_full, w_empty, (r_state != S_IDLE)};

   assign bus.waitrequest = w_wait;
   assign bus.readdata    = (bus.read && (bus.address == 4'd4)) ? w_status : 32'd0;

   assign w_unused = ^bus.writedata;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_fill_go) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_empty) w_state_nxt = ((r_fw == 8'd0) || (r_fh == 8'd0)) ? S_IDLE : S_FILL;
         S_FILL:  if (w_last_x && w_last_y) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= {w_x, w_y, w_c};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
      end
   end

   // SIZE carries w in the x byte and h in the y byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_x0 <= '0;
         r_y0 <= '0;
         r_w  <= '0;
         r_h  <= '0;
      end else if (w_accept) begin
         if (bus.address == 4'd1) begin
            r_x0 <= w_x;
            r_y0 <= w_y;
         end
         if (bus.address == 4'd2) begin
            r_w <= bus.writedata[23:16];
            r_h <= bus.writedata[31:24];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fx0  <= '0;
         r_fy0  <= '0;
         r_fw   <= '0;
         r_fh   <= '0;
         r_fcol <= '0;
         r_cx   <= '0;
         r_cy   <= '0;
      end else if (w_fill_go) begin
         r_fx0  <= r_x0;
         r_fy0  <= r_y0;
         r_fw   <= r_w;
         r_fh   <= r_h;
         r_fcol <= w_c;
         r_cx   <= '0;
         r_cy   <= '0;
      end else if (r_state == S_FILL) begin
         if (w_last_x) begin
            r_cx <= '0;
            r_cy <= r_cy + 8'd1;
         end else begin
            r_cx <= r_cx + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pix_x      <= '0;
         r_pix_y      <= '0;
         r_pix_colour <= '0;
         r_pix_plot   <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         if (r_state == S_FILL) begin
            r_pix_x      <= w_px[XW-1:0];
            r_pix_y      <= w_py[YW-1:0];
            r_pix_colour <= r_fcol;
            r_pix_plot   <= w_pinb;
         end else if (w_pop) begin
            {r_pix_x, r_pix_y, r_pix_colour} <= r_fifo[r_rd_ptr];
            r_pix_plot <= 1'b1;
         end else begin
            r_pix_plot <= 1'b0;
         end
         r_busy <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      end
   end

   assign pix_x      = r_pix_x;
   assign pix_y      = r_pix_y;
   assign pix_colour = r_pix_colour;
   assign pix_plot   = r_pix_plot;
   assign busy       = r_busy;
endmodule

// File: tb/tb_vga_fill_avalon.sv
// tb/tb_vga_fill_avalon.sv - self-checking bench for vga_fill_avalon
module tb_vga_fill_avalon;
   localparam int H_RES = 160;
   localparam int V_RES = 120;
   localparam int XW = 8;
   localparam int YW = 7;
   localparam int CW = 8;
   localparam int FIFO_DEPTH = 4;

   typedef struct {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [CW-1:0] c;
   } pix_t;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] data;
      bit          exp_push;
      pix_t        exp_pix;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [XW-1:0] pix_x;
   logic [YW-1:0] pix_y;
   logic [CW-1:0] pix_colour;
   logic          pix_plot;
   logic          busy;

   int   n_checks = 0;
   int   n_fail = 0;
   pix_t exp_q[$];

   vga_fill_avalon_if bus();

   vga_fill_avalon #(
      .H_RES(H_RES), .V_RES(V_RES), .XW(XW), .YW(YW), .CW(CW), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave),
      .pix_x(pix_x),
      .pix_y(pix_y),
      .pix_colour(pix_colour),
      .pix_plot(pix_plot),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every plotted pixel must be the next one the bench predicted.
   pix_t mon_p;
   always @(negedge clk) begin
      if (pix_plot === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_plot actual=(%0d,%0d,0x%0h) required=no pulse", pix_x, pix_y, pix_colour);
         end else begin
            mon_p = exp_q.pop_front();
            if ({pix_x, pix_y, pix_colour} !== {mon_p.x, mon_p.y, mon_p.c}) begin
               n_fail++;
               $display("FAIL plot_order actual=(%0d,%0d,0x%0h) required=(%0d,%0d,0x%0h)",
                        pix_x, pix_y, pix_colour, mon_p.x, mon_p.y, mon_p.c);
            end
         end
      end
   end

   function automatic logic [31:0] enc(input int x, input int y, input int c);
      logic [31:0] d;
      d = (32'(y) << 24) | (32'(x) << 16) | 32'(c);
      return d;
   endfunction

   function automatic pix_t mkpix(input int x, input int y, input int c);
      pix_t p;
      p.x = XW'(x);
      p.y = YW'(y);
      p.c = CW'(c);
      return p;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic av_write(input logic [3:0] a, input logic [31:0] d, output int stall);
      bus.address = a;
      bus.writedata = d;
      bus.write = 1'b1;
      stall = 0;
      #1;
      while (bus.waitrequest && stall < 2000) begin
         @(posedge clk);
         #1;
         stall++;
      end
      if (stall >= 2000) begin
         n_checks++;
         n_fail++;
         $display("FAIL write_timeout actual=stalled required=accepted addr=%0d", a);
      end
      @(posedge clk);
      #1;
      bus.write = 1'b0;
   endtask

   task automatic av_read(input logic [3:0] a, output logic [31:0] d);
      bus.address = a;
      bus.read = 1'b1;
      #1;
      d = bus.readdata;
      bus.read = 1'b0;
   endtask

   task automatic push_fill(input int x0, input int y0, input int w, input int h, input int c);
      for (int cy = 0; cy < h; cy++)
         for (int cx = 0; cx < w; cx++)
            if ((x0 + cx) < H_RES && (y0 + cy) < V_RES)
               exp_q.push_back(mkpix(x0 + cx, y0 + cy, c));
   endtask

   task automatic wait_idle(input string name);
      int cnt;
      cnt = 0;
      while ((busy || exp_q.size() != 0) && cnt < 3000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      repeat (2) @(posedge clk);
      #1;
      check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      check({name, "_busy"}, 32'(busy), 32'd0);
   endtask

   vec_t        vecs[7];
   logic [31:0] rd;
   int          st;
   int          stalls[5];
   int          cnt;

   initial begin
      vecs[0] = '{4'd0, enc(160, 5, 8'h12),   1'b0, mkpix(0, 0, 0)};
      vecs[1] = '{4'd0, enc(5, 120, 8'h34),   1'b0, mkpix(0, 0, 0)};
      vecs[2] = '{4'd0, enc(159, 119, 8'hA5), 1'b1, mkpix(159, 119, 8'hA5)};
      vecs[3] = '{4'd0, enc(0, 0, 8'h01),     1'b1, mkpix(0, 0, 8'h01)};
      vecs[4] = '{4'd0, enc(255, 127, 8'hFF), 1'b0, mkpix(0, 0, 0)};
      vecs[5] = '{4'd5, enc(1, 1, 8'h01),     1'b0, mkpix(0, 0, 0)};
      vecs[6] = '{4'd0, enc(80, 60, 8'h3C),   1'b1, mkpix(80, 60, 8'h3C)};

      bus.address = '0;
      bus.read = 1'b0;
      bus.write = 1'b0;
      bus.writedata = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      check("reset_plot", 32'(pix_plot), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_wait", 32'(bus.waitrequest), 32'd0);
      av_read(4'd4, rd);
      check("reset_status", rd, 32'h2);

      // Single PLOT latency
      exp_q.push_back(mkpix(10, 5, 8'hFF));
      av_write(4'd0, 32'h050A_00FF, st);
      check("plot1_stall", 32'(st), 32'd0);
      check("plot1_t0_plot", 32'(pix_plot), 32'd0);
      check("plot1_t0_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check("plot1_t1_plot", 32'(pix_plot), 32'd1);
      check("plot1_t1_xyc", {8'd0, pix_y, pix_x, pix_colour}, {8'd0, 7'd5, 8'd10, 8'hFF});
      @(posedge clk);
      #1;
      check("plot1_t2_plot", 32'(pix_plot), 32'd0);
      check("plot1_t2_busy", 32'(busy), 32'd0);

      // Table of PLOT writes including clipped coordinates
      foreach (vecs[i]) begin
         if (vecs[i].exp_push) exp_q.push_back(vecs[i].exp_pix);
         av_write(vecs[i].addr, vecs[i].data, st);
         check($sformatf("vec%0d_stall", i), 32'(st), 32'd0);
      end
      wait_idle("vecs");
      av_read(4'd4, rd);
      check("vecs_status", rd, 32'h2);
      av_read(4'd7, rd);
      check("unmapped_read", rd, 32'd0);

      // Clipped fill at the bottom-right corner
      av_write(4'd1, enc(158, 118, 0), st);
      av_write(4'd2, enc(4, 3, 0), st);
      push_fill(158, 118, 4, 3, 8'h3C);
      check("clip_expected_count", 32'(exp_q.size()), 32'd4);
      av_write(4'd3, enc(0, 0, 8'h3C), st);
      cnt = 0;
      while (busy && cnt < 200) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check("clip_busy_edges", 32'(cnt), 32'd13);
      wait_idle("clip");

      // Back-pressure: PLOTs during an 8x8 fill
      av_write(4'd1, enc(0, 0, 0), st);
      av_write(4'd2, enc(8, 8, 0), st);
      push_fill(0, 0, 8, 8, 8'h11);
      av_write(4'd3, enc(0, 0, 8'h11), st);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(mkpix(100 + i, 50 + i, 8'hC0 + i));
         av_write(4'd0, enc(100 + i, 50 + i, 8'hC0 + i), stalls[i]);
      end
      for (int i = 0; i < 4; i++) check($sformatf("bp_stall%0d", i), 32'(stalls[i]), 32'd0);
      check("bp_stall4_waited", 32'(stalls[4] > 50), 32'd1);
      wait_idle("bp");

      // Empty fill after queued PLOTs; FILL during DRAIN must wait
      av_write(4'd2, enc(0, 5, 0), st);
      exp_q.push_back(mkpix(1, 2, 8'h21));
      exp_q.push_back(mkpix(3, 4, 8'h22));
      av_write(4'd0, enc(1, 2, 8'h21), st);
      av_write(4'd0, enc(3, 4, 8'h22), st);
      av_write(4'd3, enc(0, 0, 8'h55), st);
      check("empty_fill_stall", 32'(st), 32'd0);
      av_read(4'd4, rd);
      check("empty_fill_drain_status", rd & 32'h1, 32'h1);
      bus.address = 4'd3;
      bus.writedata = enc(0, 0, 8'h66);
      bus.write = 1'b1;
      #1;
      check("fill_in_drain_wait", 32'(bus.waitrequest), 32'd1);
      av_write(4'd3, enc(0, 0, 8'h66), st);
      check("fill_in_drain_stall", 32'(st), 32'd1);
      wait_idle("empty_fill");

      // Reset in the middle of a 10x10 fill
      av_write(4'd1, enc(20, 20, 0), st);
      av_write(4'd2, enc(10, 10, 0), st);
      push_fill(20, 20, 10, 10, 8'h77);
      av_write(4'd3, enc(0, 0, 8'h77), st);
      repeat (30) @(posedge clk);
      #1;
      check("midfill_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("post_reset_plot%0d", i), 32'(pix_plot), 32'd0);
         @(posedge clk);
         #1;
      end
      check("post_reset_busy", 32'(busy), 32'd0);
      av_read(4'd4, rd);
      check("post_reset_status", rd, 32'h2);
      exp_q.push_back(mkpix(7, 9, 8'hE1));
      av_write(4'd0, enc(7, 9, 8'hE1), st);
      check("post_reset_plot_stall", 32'(st), 32'd0);
      wait_idle("post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_fill_avalon.md
# vga_fill_avalon

Avalon-MM slave that replaces the single-pixel VGA plot port with a buffered pixel queue plus a hardware rectangle-fill engine. It sits between the Avalon bus and the `vga_adapter` plot interface (`x`, `y`, `colour`, `plot`). Software can queue individual pixels without stalling, or fill a clipped rectangle at one pixel per clock. Screen size, coordinate widths, colour width and queue depth are parameters.

## Interface
- `H_RES`, 160, screen width in pixels
- `V_RES`, 120, screen height in pixels
- `XW`, 8, x coordinate width; must satisfy 2^XW ≥ H_RES
- `YW`, 7, y coordinate width; must satisfy 2^YW ≥ V_RES
- `CW`, 8, colour width; must be ≤ 16
- `FIFO_DEPTH`, 4, pixel queue entries; power of two, ≥ 2

- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `address` in 4: word offset.
- `read` in 1: Avalon read strobe.
- `readdata` out 32: combinational, zero wait states.
- `write` in 1: Avalon write strobe.
- `writedata` in 32: write data.
- `waitrequest` out 1: combinational; a write is accepted only on a rising edge where `write`=1 and `waitrequest`=0.
- `pix_x` out XW: registered pixel x.
- `pix_y` out YW: registered pixel y.
- `pix_colour` out CW: registered pixel colour.
- `pix_plot` out 1: registered; one pulse per plotted pixel.
- `busy` out 1: registered; 1 while the FIFO is non-empty or the state is not IDLE.

## Operation
- Field encoding, used by every register below:
  - y = `writedata[24+YW-1:24]`
  - x = `writedata[16+XW-1:16]`
  - colour = `writedata[CW-1:0]`
- Offset 0, PLOT:
  - If x<H_RES and y<V_RES, push {x,y,colour} into the FIFO.
  - Otherwise accept the write and drop it; `waitrequest` stays 0.
  - If the FIFO is full, hold `waitrequest`=1 until an entry drains. This applies only to in-bounds writes.
- Offset 1, ORIGIN: latch x0 and y0. Always accepted, even while a fill runs; a running fill is unaffected.
- Offset 2, SIZE: latch w and h, each 8 bits, as a pixel count. w=0 or h=0 gives an empty fill. Always accepted.
- Offset 3, FILL:
  - Latch colour and snapshot ORIGIN and SIZE into fill working registers.
  - Transition IDLE→DRAIN.
  - If the state is not IDLE, hold `waitrequest`=1 until the engine returns to IDLE.
- Offset 4, STATUS (read):
  - bit0 = state≠IDLE
  - bit1 = FIFO empty
  - bit2 = FIFO full
  - bits[7:4] = FIFO occupancy
  - All other bits are 0.
- Reads from any other offset return 0. Writes to offsets 4–15 are accepted and ignored. Reads never stall.
- State machine:
  - IDLE: on each edge, if the FIFO is non-empty, pop one entry into the output register with `pix_plot`=1. Otherwise `pix_plot`=0. On FILL accept → DRAIN.
  - DRAIN: keep popping the FIFO one entry per edge. On the first edge where the FIFO is empty → FILL. If w=0 or h=0 → IDLE instead.
  - FILL: raster scan with cx running 0..w-1 inner and cy running 0..h-1 outer, one position per edge.
    - Compute px=x0+cx in XW+1 bits and py=y0+cy in YW+1 bits, with no wrap-around.
    - The output register loads {px,py,colour} with `pix_plot`=(px<H_RES && py<V_RES). Off-screen positions consume a cycle with `pix_plot`=0.
    - On the edge that processes (w-1,h-1) → IDLE.
    - The FIFO is not popped in FILL. PLOT writes accepted during FILL queue up and drain after the fill, which preserves program order.
- Simultaneous events:
  - A FIFO push and pop on the same edge leave occupancy unchanged. A push while full is impossible because `waitrequest` blocks it.
  - When full and a pop occurs in the same cycle, `waitrequest` is still 1 that cycle; the write completes on the next edge.

## Timing
- Reset (synchronous, one edge):
  - FIFO emptied; state=IDLE.
  - ORIGIN, SIZE and fill registers cleared to 0.
  - `pix_x`, `pix_y`, `pix_colour`, `pix_plot` and `busy` = 0.
  - `waitrequest`=0 after reset.
  - Asserting reset mid-fill or mid-drain aborts the operation and discards queued pixels; no further `pix_plot` pulses occur.
- PLOT latency: a write accepted at edge T into an empty FIFO while IDLE gives `pix_plot`=1 during the cycle after edge T+1, for exactly 1 cycle.
- FILL latency with an empty FIFO:
  - Accept at edge T; DRAIN at T+1; FILL begins at T+2.
  - First pixel is visible after edge T+2. The last pixel is visible after edge T+1+w·h.
  - IDLE is reached at T+1+w·h.
- Throughput: maximum one pixel per clock in every mode.

## Test plan
- Reset, then write 0x05_0A_00_FF at offset 0 -> exactly one `pix_plot` pulse with x=10, y=5, colour=0xFF, 2 edges after acceptance; `busy` returns to 0.
- Write x=160 at offset 0, then y=120 at offset 0 -> no `waitrequest`, no `pix_plot`, STATUS bit1=1.
- Hold the sink busy with a running 8×8 fill and issue 5 back-to-back PLOT writes with `FIFO_DEPTH`=4 -> 4 accepted; 5th stalls until the fill ends; afterwards 5 pulses in write order.
- ORIGIN x0=158 y0=118, SIZE w=4 h=3, FILL colour 0x3C -> 12 FILL cycles; pulses only at (158,118), (159,118), (158,119), (159,119); `busy` clears at T+13.
- FILL with w=0 after 2 queued PLOTs -> 2 pulses, then IDLE, no fill pulses; a second FILL written during DRAIN sees `waitrequest`=1.
- Assert `reset` in the middle of a 10×10 fill -> `pix_plot`=0 from the next edge, STATUS reads 0x2, and a subsequent PLOT works normally.
